// File: rtl/reg_sel_sequencer_if.sv
// reg_sel_sequencer_if: register-index handshake between sequencer (master) and decoder (slave)
interface reg_sel_sequencer_if;
  logic [3:0] reg_idx;
  logic       idx_valid;
  logic       idx_write;
  logic       idx_ready;
  modport master (output reg_idx, idx_valid, idx_write, input idx_ready);
  modport slave (input reg_idx, idx_valid, idx_write, output idx_ready);
endinterface

// File: rtl/reg_sel_sequencer.sv
// reg_sel_sequencer: latches IR, extracts fields, issues register operands as indexed beats.
// Optional SEL_R0_SKIP_EN: read beats to register 0 are dropped without a handshake.
module reg_sel_sequencer #(
  parameter int          C_WIDTH  = 19,
  parameter logic [31:0] IR_RESET = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 clr_n,
  input  logic [31:0]          ir_in,
  input  logic                 ir_load,
  input  logic                 start,
  reg_sel_sequencer_if.master  sel,
  output logic [31:0]          ir_q,
  output logic [31:0]          c_sext,
  output logic                 busy,
  output logic                 done
);
  typedef enum logic [2:0] {IDLE, BEAT1, BEAT2, BEAT3, DONE} state_t;
  state_t state, state_n, nxt;
  logic [1:0] cls, slot;
  logic [3:0] ra, rb, rc;
  logic [2:0][3:0] s_idx;
  logic [2:0] s_wr, s_en, rem;
  logic beat_n;
  assign cls    = ir_q[31:30];
  assign ra     = ir_q[26:23];
  assign rb     = ir_q[22:19];
  assign rc     = ir_q[18:15];
  assign c_sext = {{(32-C_WIDTH){ir_q[C_WIDTH-1]}}, ir_q[C_WIDTH-1:0]};
  assign busy   = state != IDLE;
  // Three beat slots per class; slot k maps to state BEAT(k+1), disabled slots are skipped.
  always_comb begin
    s_idx[0] = rb;
    s_wr[0]  = 1'b0;
    s_en[0]  = cls != 2'b11;
    s_idx[1] = cls == 2'b00 ? rc : ra;
    s_wr[1]  = cls == 2'b01;
    s_en[1]  = cls != 2'b11;
    s_idx[2] = ra;
    s_wr[2]  = 1'b1;
    s_en[2]  = cls == 2'b00;
`ifdef SEL_R0_SKIP_EN
    s_en[0]  = s_en[0] & (|s_idx[0]);
    s_en[1]  = s_en[1] & (s_wr[1] | (|s_idx[1]));
`else
    s_en[2]  = s_en[2];
`endif
    rem = state == IDLE  ? s_en :
          state == BEAT1 ? s_en & 3'b110 :
          state == BEAT2 ? s_en & 3'b100 : 3'b000;
    nxt = rem[0] ? BEAT1 : rem[1] ? BEAT2 : rem[2] ? BEAT3 : DONE;
    state_n = state == IDLE ? ((start && !ir_load) ? nxt : IDLE) :
              state == DONE ? IDLE :
              (sel.idx_valid && sel.idx_ready) ? nxt : state;
    beat_n = state_n == BEAT1 || state_n == BEAT2 || state_n == BEAT3;
    slot   = state_n == BEAT2 ? 2'd1 : state_n == BEAT3 ? 2'd2 : 2'd0;
  end
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state         <= IDLE;
      ir_q          <= IR_RESET;
      sel.reg_idx   <= '0;
      sel.idx_valid <= 1'b0;
      sel.idx_write <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_n;
      sel.idx_valid <= beat_n;
      sel.reg_idx   <= beat_n ? s_idx[slot] : 4'd0;
      sel.idx_write <= beat_n & s_wr[slot];
      done          <= state_n == DONE;
      if (state == IDLE && ir_load) ir_q <= ir_in;
    end
  end
endmodule

// File: tb/tb_reg_sel_sequencer.sv
// tb_reg_sel_sequencer: directed scenarios for the register-select sequencer.
module tb_reg_sel_sequencer;
  logic clk = 1'b0, clr_n = 1'b0, ir_load = 1'b0, start = 1'b0;
  logic [31:0] ir_in = '0, ir_q, c_sext;
  logic busy, done;
  int checks = 0, failures = 0;
  reg_sel_sequencer_if sel ();
  always #5 clk = ~clk;
  reg_sel_sequencer dut (
    .clk(clk), .clr_n(clr_n), .ir_in(ir_in), .ir_load(ir_load), .start(start),
    .sel(sel), .ir_q(ir_q), .c_sext(c_sext), .busy(busy), .done(done)
  );

  task automatic load(input logic [31:0] v);
    @(negedge clk) ir_in = v; ir_load = 1'b1;
    @(negedge clk) ir_load = 1'b0;
  endtask

  task automatic test_reset;
    sel.idx_ready = 1'b0;
    clr_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({ir_q, sel.reg_idx, sel.idx_valid, sel.idx_write, busy, done} !== 40'd0) begin
      failures++; $display("FAIL reset: got ir=%h idx=%h v=%b w=%b busy=%b done=%b want all 0",
        ir_q, sel.reg_idx, sel.idx_valid, sel.idx_write, busy, done);
    end
    clr_n = 1'b1;
  endtask

  task automatic test_r3;
    logic [4:0] e [3];
    e = '{5'h05, 5'h07, 5'h13};
    load(32'h01AB8000);
    checks++;
    if (ir_q !== 32'h01AB8000) begin failures++; $display("FAIL r3_irq: got %h want 01ab8000", ir_q); end
    sel.idx_ready = 1'b1; start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({sel.idx_valid, busy, done, sel.idx_write, sel.reg_idx} !== {3'b110, e[i]}) begin
        failures++; $display("FAIL r3_beat%0d: got v=%b busy=%b done=%b w=%b idx=%0d want w=%b idx=%0d",
          i, sel.idx_valid, busy, done, sel.idx_write, sel.reg_idx, e[i][4], e[i][3:0]);
      end
      @(negedge clk);
    end
    checks++;
    if ({done, sel.idx_valid, busy} !== 3'b101) begin
      failures++; $display("FAIL r3_done: got done=%b v=%b busy=%b want 1 0 1", done, sel.idx_valid, busy);
    end
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b00) begin failures++; $display("FAIL r3_idle: got done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_ri_back_to_back;
    logic [4:0] e [2];
    e = '{5'h04, 5'h12};
    load(32'h4127FFFF);
    checks++;
    if (c_sext !== 32'hFFFFFFFF) begin failures++; $display("FAIL ri_sext: got %h want ffffffff", c_sext); end
    sel.idx_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if ({sel.idx_valid, sel.idx_write, sel.reg_idx} !== {1'b1, e[i]}) begin
          failures++; $display("FAIL ri%0d_beat%0d: got v=%b w=%b idx=%0d want v=1 w=%b idx=%0d",
            r, i, sel.idx_valid, sel.idx_write, sel.reg_idx, e[i][4], e[i][3:0]);
        end
        @(negedge clk);
      end
      checks++;
      if ({done, sel.idx_valid} !== 2'b10) begin failures++; $display("FAIL ri%0d_done: got done=%b v=%b want 1 0", r, done, sel.idx_valid); end
      @(negedge clk);
    end
  endtask

  task automatic test_st;
    logic [4:0] e [2];
    int n;
`ifdef SEL_R0_SKIP_EN
    e = '{5'h01, 5'h01}; n = 1;
`else
    e = '{5'h00, 5'h01}; n = 2;
`endif
    load(32'h80800000);
    sel.idx_ready = 1'b1; start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < n; i++) begin
      checks++;
      if ({sel.idx_valid, sel.idx_write, sel.reg_idx} !== {1'b1, e[i]}) begin
        failures++; $display("FAIL st_beat%0d: got v=%b w=%b idx=%0d want v=1 w=%b idx=%0d",
          i, sel.idx_valid, sel.idx_write, sel.reg_idx, e[i][4], e[i][3:0]);
      end
      @(negedge clk);
    end
    checks++;
    if ({done, sel.idx_valid} !== 2'b10) begin failures++; $display("FAIL st_done: got done=%b v=%b want 1 0", done, sel.idx_valid); end
    @(negedge clk);
  endtask

  task automatic test_nop;
    load(32'hF8000000);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    checks++;
    if ({done, sel.idx_valid, busy} !== 3'b101) begin
      failures++; $display("FAIL nop_done: got done=%b v=%b busy=%b want 1 0 1", done, sel.idx_valid, busy);
    end
    @(negedge clk);
    checks++;
    if ({done, sel.idx_valid, busy} !== 3'b000) begin
      failures++; $display("FAIL nop_idle: got done=%b v=%b busy=%b want 0 0 0", done, sel.idx_valid, busy);
    end
  endtask

  task automatic test_backpressure;
    load(32'h01AB8000);
    sel.idx_ready = 1'b1; start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk) sel.idx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({sel.idx_valid, sel.idx_write, sel.reg_idx} !== 6'b10_0111) begin
        failures++; $display("FAIL bp_hold%0d: got v=%b w=%b idx=%0d want v=1 w=0 idx=7",
          i, sel.idx_valid, sel.idx_write, sel.reg_idx);
      end
    end
    sel.idx_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({sel.idx_valid, sel.idx_write, sel.reg_idx} !== 6'b11_0011) begin
      failures++; $display("FAIL bp_resume: got v=%b w=%b idx=%0d want v=1 w=1 idx=3", sel.idx_valid, sel.idx_write, sel.reg_idx);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL bp_done: got %b want 1", done); end
    @(negedge clk);
  endtask

  task automatic test_ignore;
    ir_in = 32'h4127FFFF; ir_load = 1'b1; start = 1'b1;
    @(negedge clk) ir_load = 1'b0; start = 1'b0;
    checks++;
    if ({ir_q, busy} !== {32'h4127FFFF, 1'b0}) begin
      failures++; $display("FAIL load_wins: got ir=%h busy=%b want 4127ffff 0", ir_q, busy);
    end
    load(32'h01AB8000);
    sel.idx_ready = 1'b0; start = 1'b1;
    @(negedge clk) ir_in = 32'hFFFFFFFF; ir_load = 1'b1;
    @(negedge clk) ir_load = 1'b0; start = 1'b0;
    checks++;
    if ({ir_q, sel.reg_idx, sel.idx_valid} !== {32'h01AB8000, 4'd5, 1'b1}) begin
      failures++; $display("FAIL busy_ignore: got ir=%h idx=%0d v=%b want 01ab8000 5 1", ir_q, sel.reg_idx, sel.idx_valid);
    end
    sel.idx_ready = 1'b1;
    @(negedge clk) sel.idx_ready = 1'b0;
    @(negedge clk) clr_n = 1'b0;
    #1;
    checks++;
    if ({ir_q, sel.reg_idx, sel.idx_valid, sel.idx_write, busy, done} !== 40'd0) begin
      failures++; $display("FAIL mid_reset: got ir=%h idx=%h v=%b w=%b busy=%b done=%b want all 0",
        ir_q, sel.reg_idx, sel.idx_valid, sel.idx_write, busy, done);
    end
    @(negedge clk) clr_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({done, busy, sel.idx_valid} !== 3'b000) begin
      failures++; $display("FAIL post_reset: got done=%b busy=%b v=%b want 0 0 0", done, busy, sel.idx_valid);
    end
  endtask

  initial begin
    test_reset;
    test_r3;
    test_ri_back_to_back;
    test_st;
    test_nop;
    test_backpressure;
    test_ignore;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_sel_sequencer.md
Name: reg_sel_sequencer

Overview:
- Upstream stage of the 4-to-16 register-select decoder.
- Latches the instruction word and extracts the Ra/Rb/Rc fields and the sign-extended constant.
- A small FSM then issues the instruction's register operands one at a time as 4-bit indices, over a valid/ready handshake.
- The decoder consumes each index to assert the matching register enable.

Parameters:
- C_WIDTH, 19, width of the IR constant field c2 (IR[18:0]) before sign extension to 32 bits.
- IR_RESET, 32'h0000_0000, value loaded into the IR on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clr_n  input  1  asynchronous active-low reset.
- ir_in  input  32  instruction word from the memory data register.
- ir_load  input  1  latch ir_in into the IR (IDLE only).
- start  input  1  begin operand sequencing for the latched IR (IDLE only).
- idx_ready  input  1  downstream decoder accepts the current index.
- ir_q  output  32  latched IR.
- c_sext  output  32  IR[C_WIDTH-1:0] sign-extended from bit C_WIDTH-1; combinational from ir_q.
- reg_idx  output  4  register index of the current beat.
- idx_valid  output  1  reg_idx is valid.
- idx_write  output  1  current beat is a destination (write), not a source (read).
- busy  output  1  FSM not in IDLE.
- done  output  1  one-cycle pulse after the final beat, or after a NOP.

Behaviour:
- Reset: while clr_n is low, the following hold immediately (asynchronous) and FSM = IDLE.
  - ir_q = IR_RESET.
  - reg_idx = 0.
  - idx_valid = 0.
  - idx_write = 0.
  - busy = 0.
  - done = 0.
- Reset asserted mid-sequence aborts the sequence; no done pulse is issued.
- IR fields: opcode = IR[31:27], ra = IR[26:23], rb = IR[22:19], rc = IR[18:15].
- Opcode class is decided by opcode[4:3]. Beats are issued in the order listed:
  - 00 R3: rb (read), rc (read), ra (write).
  - 01 RI: rb (read), ra (write).
  - 10 ST: rb (read), ra (read).
  - 11 NOP: no beats.
- States: IDLE, BEAT1, BEAT2, BEAT3, DONE.
- IDLE:
  - ir_load=1 → ir_q <= ir_in at the next edge.
  - start=1 (with ir_load=0) → go to BEAT1, or go straight to DONE for a NOP.
  - ir_load and start in the same cycle: the load wins and start is ignored.
- BEATn:
  - reg_idx, idx_write and idx_valid=1 are registered outputs, valid the cycle after entering the state.
  - They are held stable until idx_valid && idx_ready.
  - On that handshake, go to the next beat, or to DONE after the last beat for the class.
- Latency: start at cycle N → first idx_valid at N+1. With idx_ready tied high, one beat per cycle.
- DONE: done=1 and idx_valid=0 for exactly one cycle, then IDLE.
- busy = 1 in every state except IDLE.
- ir_load and start outside IDLE are ignored; ir_q is held constant for the whole sequence.
- idx_ready while idx_valid=0 has no effect.
- Back-to-back operation: a start in the cycle after done is accepted.

Optional Feature:
- Macro: SEL_R0_SKIP_EN.
- Defined:
  - Any read beat whose index is 0 is not issued; the FSM advances past it without a handshake.
  - This costs no extra cycle.
  - If every beat is skipped, done follows one cycle after start.
  - Write beats to index 0 are still issued.
- Undefined: all beats are issued as listed.

Test Plan:
- R3: ir_in=32'h01AB8000, ir_load, then start, idx_ready=1.
  - Beats (5,r), (7,r), (3,w) on consecutive cycles.
  - done pulses once, busy falls.
- RI: ir_in=32'h4127FFFF.
  - c_sext=32'hFFFFFFFF.
  - Beats (4,r), (2,w), then done.
- ST with rb=0: ir_in=32'h80800000.
  - Macro off: beats (0,r), (1,r).
  - Macro on: single beat (1,r).
- NOP and backpressure:
  - NOP ir_in=32'hF8000000: no idx_valid; done exactly one cycle after start.
  - R3 with idx_ready low for 3 cycles on beat 2: reg_idx=7, idx_valid stay stable; sequence resumes on release.
- Reset/ignore:
  - clr_n low during beat 2: all outputs 0 immediately, no done pulse.
  - ir_load while busy leaves ir_q unchanged.
